// File: rtl/musicrom_arbiter.sv
// Round-robin arbiter that shares one synchronous music ROM between the music
// player, the sound-effect player and the CPU; one access every three clocks.
module musicrom_arbiter #(
    parameter int unsigned ROM_WIDTH = 17,
    parameter int unsigned NREQ      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*ROM_WIDTH-1:0] req_addr,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           rd_valid,
    output logic [7:0]                rd_data,
    output logic [ROM_WIDTH-1:0]      musicrom_addr,
    input  logic [7:0]                musicrom_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             rr_ptr_q, rr_ptr_d;
    logic [1:0]             winner_q, winner_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic [NREQ-1:0]        rd_valid_q, rd_valid_d;
    logic [7:0]             rd_data_q, rd_data_d;
    logic [ROM_WIDTH-1:0]   addr_q, addr_d;

    logic [ROM_WIDTH-1:0]   addr_arr [NREQ];
    logic                   found;
    logic [1:0]             win;
    logic [2:0]             sum;
    logic [1:0]             cand;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[i*ROM_WIDTH +: ROM_WIDTH];
        end
    end

    // Search starts at rr_ptr and wraps modulo 3; first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum  = {1'b0, rr_ptr_q} + 3'(i);
            cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        winner_d   = winner_q;
        gnt_d      = '0;
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    addr_d     = addr_arr[win];
                    gnt_d[win] = 1'b1;
                    winner_d   = win;
                    rr_ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rd_data_d            = musicrom_data_out;
                rd_valid_d[winner_q] = 1'b1;
                state_d              = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            winner_q   <= '0;
            gnt_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            winner_q   <= winner_d;
            gnt_q      <= gnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            addr_q     <= addr_d;
        end
    end

    assign gnt           = gnt_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign musicrom_addr = addr_q;

endmodule

// File: tb/tb_musicrom_arbiter.sv
// Scoreboard bench for musicrom_arbiter: expected grants and reads are queued
// as stimulus is driven and matched when the arbiter pulses gnt / rd_valid.
module tb_musicrom_arbiter;

    localparam int unsigned RW = 17;

    logic            clk;
    logic            reset;
    logic [2:0]      req;
    logic [3*RW-1:0] req_addr;
    logic [2:0]      gnt;
    logic [2:0]      rd_valid;
    logic [7:0]      rd_data;
    logic [RW-1:0]   musicrom_addr;
    logic [7:0]      musicrom_data_out;

    musicrom_arbiter #(.ROM_WIDTH(RW), .NREQ(3)) dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .req_addr          (req_addr),
        .gnt               (gnt),
        .rd_valid          (rd_valid),
        .rd_data           (rd_data),
        .musicrom_addr     (musicrom_addr),
        .musicrom_data_out (musicrom_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [RW-1:0] a);
        if (a == 17'h00013) return 8'h05;
        return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'hA5;
    endfunction

    // Synchronous ROM: address registered on one edge, data valid after it.
    logic [RW-1:0] rom_a_q;
    always @(posedge clk) rom_a_q <= musicrom_addr;
    assign musicrom_data_out = rom_byte(rom_a_q);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [2:0]    oh;
        logic [RW-1:0] addr;
        logic [7:0]    data;
        int            when;
    } exp_t;

    exp_t gq[$];
    exp_t dq[$];

    task automatic push_grant(input int r, input logic [RW-1:0] a, input int gcyc);
        exp_t e;
        e.oh   = 3'(1 << r);
        e.addr = a;
        e.data = '0;
        e.when = gcyc;
        gq.push_back(e);
    endtask

    task automatic push_acc(input int r, input logic [RW-1:0] a, input int gcyc);
        exp_t e;
        push_grant(r, a, gcyc);
        e.oh   = 3'(1 << r);
        e.addr = a;
        e.data = rom_byte(a);
        e.when = gcyc + 2;
        dq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (gnt != 3'b000 || rd_valid != 3'b000)
            chk_eq("gnt_rv_excl", 32'((gnt != 3'b000) && (rd_valid != 3'b000)), 32'd0);
        if (gnt != 3'b000) begin
            if (gq.size() == 0) begin
                chk_eq("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
                e = gq.pop_front();
                chk_eq("gnt", 32'(gnt), 32'(e.oh));
                chk_eq("gnt_cycle", 32'(cyc), 32'(e.when));
                chk_eq("rom_addr", 32'(musicrom_addr), 32'(e.addr));
            end
        end
        if (rd_valid != 3'b000) begin
            if (dq.size() == 0) begin
                chk_eq("rv_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                e = dq.pop_front();
                chk_eq("rd_valid", 32'(rd_valid), 32'(e.oh));
                chk_eq("rv_cycle", 32'(cyc), 32'(e.when));
                chk_eq("rd_data", 32'(rd_data), 32'(e.data));
            end
        end
    end

    task automatic at_edge(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [RW-1:0] a);
        req_addr[i*RW +: RW] = a;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        at_edge(2);
        reset = 1'b0;
    endtask

    task automatic drained(input string tag);
        chk_eq({tag, "_gq_empty"}, 32'(gq.size()), 32'd0);
        chk_eq({tag, "_dq_empty"}, 32'(dq.size()), 32'd0);
        gq.delete();
        dq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int r;
        logic [RW-1:0] a;
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        do_reset();
        chk_eq("rst_gnt", 32'(gnt), 32'd0);
        chk_eq("rst_rv", 32'(rd_valid), 32'd0);
        chk_eq("rst_data", 32'(rd_data), 32'd0);
        chk_eq("rst_addr", 32'(musicrom_addr), 32'd0);

        // Single request
        k = cyc;
        set_addr(0, 17'h00013);
        req = 3'b001;
        push_acc(0, 17'h00013, k + 1);
        at_edge(1);
        req = '0;
        at_edge(6);
        drained("single");
        chk_eq("addr_hold", 32'(musicrom_addr), 32'h13);
        chk_eq("data_hold", 32'(rd_data), 32'h05);

        // All three held after reset: 0,1,2,0 three cycles apart
        do_reset();
        k = cyc;
        set_addr(0, 17'h00100);
        set_addr(1, 17'h1ABCD);
        set_addr(2, 17'h0FFFF);
        req = 3'b111;
        push_acc(0, 17'h00100, k + 1);
        push_acc(1, 17'h1ABCD, k + 4);
        push_acc(2, 17'h0FFFF, k + 7);
        push_acc(0, 17'h00100, k + 10);
        at_edge(10);
        req = '0;
        at_edge(6);
        drained("simul");

        // Rotation: grant 1, then 101 picks 2 first; req change mid-access
        // is ignored, then pointer 0 picks requester 0 out of 011.
        do_reset();
        k = cyc;
        set_addr(0, 17'h00321);
        set_addr(1, 17'h10001);
        set_addr(2, 17'h0BEEF);
        req = 3'b010;
        push_acc(1, 17'h10001, k + 1);
        at_edge(1);
        req = '0;
        at_edge(3);
        k = cyc;
        req = 3'b101;
        push_acc(2, 17'h0BEEF, k + 1);
        push_acc(0, 17'h00321, k + 4);
        at_edge(1);
        req = 3'b011;
        at_edge(3);
        req = '0;
        at_edge(6);
        drained("rotate");

        // Reset during WAIT aborts the access
        k = cyc;
        set_addr(1, 17'h0AAAA);
        req = 3'b010;
        push_grant(1, 17'h0AAAA, k + 1);
        at_edge(1);
        req   = '0;
        reset = 1'b1;
        at_edge(1);
        reset = 1'b0;
        chk_eq("abort_gnt", 32'(gnt), 32'd0);
        chk_eq("abort_rv", 32'(rd_valid), 32'd0);
        chk_eq("abort_data", 32'(rd_data), 32'd0);
        chk_eq("abort_addr", 32'(musicrom_addr), 32'd0);
        k = cyc;
        set_addr(2, 17'h05555);
        req = 3'b110;
        push_acc(1, 17'h0AAAA, k + 1);
        at_edge(1);
        req = '0;
        at_edge(6);
        drained("abort");

        // Late pulse on req1 during WAIT and addr0 change are both ignored
        k = cyc;
        set_addr(0, 17'h01234);
        req = 3'b001;
        push_acc(0, 17'h01234, k + 1);
        at_edge(1);
        req = 3'b010;
        set_addr(0, 17'h05678);
        at_edge(1);
        req = '0;
        at_edge(6);
        drained("late");

        for (int i = 0; i < 4; i++) begin
            r = int'($urandom_range(0, 2));
            a = RW'($urandom);
            k = cyc;
            set_addr(r, a);
            req = 3'(1 << r);
            push_acc(r, a, k + 1);
            at_edge(1);
            req = '0;
            at_edge(4);
        end
        at_edge(3);
        drained("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/musicrom_arbiter.md
MUSICROM_ARBITER -- requirements
Module: musicrom_arbiter

Interface
REQ-001 Parameter ROM_WIDTH, default 17, SHALL set the width of all ROM addresses.
REQ-002 Parameter NREQ, fixed at 3, SHALL set the requester count: index 0 = music player, 1 = sound-effect player, 2 = CPU read port.
REQ-003 Port clk, input, 1 bit, SHALL be the single system clock.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port req, input, [2:0], SHALL carry one access-request level per requester.
REQ-006 Port req_addr, input, [3*ROM_WIDTH-1:0], SHALL carry the packed request addresses, requester i at [i*ROM_WIDTH +: ROM_WIDTH].
REQ-007 Port gnt, output reg, [2:0], SHALL carry a one-hot, one-cycle grant pulse.
REQ-008 Port rd_valid, output reg, [2:0], SHALL carry a one-hot, one-cycle read-data-valid pulse.
REQ-009 Port rd_data, output reg, [7:0], SHALL carry the last captured ROM byte, shared by all requesters.
REQ-010 Port musicrom_addr, output reg, [ROM_WIDTH-1:0], SHALL drive the shared music ROM address.
REQ-011 Port musicrom_data_out, input, [7:0], SHALL return ROM data; the ROM is synchronous with a one-clock registered address.

Function
REQ-012 The block SHALL implement the states IDLE, WAIT and CAPTURE.
REQ-013 IDLE SHALL sample req and req_addr; no request SHALL leave the state in IDLE with all outputs except rd_data unchanged.
REQ-014 IDLE with at least one req set SHALL select a winner by round-robin, starting the search at index rr_ptr and proceeding rr_ptr, rr_ptr+1, ... modulo 3.
REQ-015 On a win, the block SHALL register musicrom_addr <= winner's req_addr, gnt[winner] <= 1, latch winner index, set rr_ptr <= (winner+1) mod 3, and go to WAIT.
REQ-016 WAIT SHALL clear gnt and go to CAPTURE unconditionally, which gives the ROM one cycle to register the address.
REQ-017 CAPTURE SHALL register rd_data <= musicrom_data_out and rd_valid[winner] <= 1, and go to IDLE.
REQ-018 rd_valid SHALL be cleared in the cycle after it is set.
REQ-019 Latency SHALL be: gnt visible 1 cycle after the IDLE sample edge, rd_valid and rd_data visible 3 cycles after it.
REQ-020 Maximum throughput SHALL be one access per 3 clocks.
REQ-021 gnt and rd_valid SHALL never have more than one bit set, and SHALL never be asserted in the same cycle.
REQ-022 req SHALL be sampled only in IDLE; changes to req or req_addr during WAIT/CAPTURE SHALL be ignored for the access in flight.
REQ-023 A req still high in the IDLE cycle following its rd_valid SHALL be treated as a new request and arbitrated normally, so it cannot repeat while others wait.
REQ-024 A req withdrawn before being sampled in IDLE SHALL produce no access, no gnt and no rd_valid.
REQ-025 musicrom_addr SHALL hold its last value outside grant cycles.
REQ-026 rd_data SHALL hold until the next CAPTURE.
REQ-027 rr_ptr SHALL be 2 bits; the value 3 SHALL never occur, and increment from 2 SHALL wrap to 0.

Reset
REQ-028 reset SHALL set state=IDLE, rr_ptr=0, gnt=0, rd_valid=0, rd_data=0 and musicrom_addr=0 at the next clock edge.
REQ-029 reset SHALL take priority over all state transitions.
REQ-030 reset asserted in WAIT or CAPTURE SHALL abort the access, and no rd_valid SHALL be issued for it.
REQ-031 The first IDLE cycle after reset deasserts SHALL arbitrate normally.

Verification
REQ-032 Single request: req=3'b001, addr0=17'h00013, ROM[0x13]=8'h05 -> gnt=001 at cycle +1, musicrom_addr=0x00013, rd_valid=001 with rd_data=8'h05 at cycle +3.
REQ-033 Simultaneous: req=3'b111 held after reset -> grant order 0,1,2,0, grants spaced exactly 3 cycles apart, each rd_valid 2 cycles after its gnt.
REQ-034 Rotation: rr_ptr=2 (after granting 1), req=3'b101 -> requester 2 is granted before 0, then rr_ptr=0.
REQ-035 Reset mid-op: reset asserted in WAIT for requester 1 -> no rd_valid; all outputs 0 next cycle; next grant starts from index 0.
REQ-036 Withdrawn/late: req1 pulses high only during WAIT of another access -> never granted; addr0 changed during WAIT -> rd_data reflects the original address.
